// File: rtl/ctrl_mc_if.sv
// Fetch and data-memory handshake bundle between ctrl_mc and the memory side.
// master = controller (issues requests), slave = memory (returns strobes).
interface ctrl_mc_if;
    logic [31:0] instr_read;
    logic        instr_req;
    logic        instr_valid;
    logic        mem_req;
    logic        mem_we;
    logic        mem_valid;

    modport master (
        input  instr_read, instr_valid, mem_valid,
        output instr_req, mem_req, mem_we
    );

    modport slave (
        output instr_read, instr_valid, mem_valid,
        input  instr_req, mem_req, mem_we
    );
endinterface

// File: rtl/ctrl_mc.sv
// Multi-cycle RV32I control FSM: FETCH -> EXEC -> (MEM) -> WB, sticky TRAP on illegal opcodes.
// Datapath select outputs follow the latched opcode class through EXEC, MEM and WB.
module ctrl_mc #(
    parameter int unsigned EXEC_CYCLES = 2,
    parameter int unsigned TIMER_BITS  = 4,
    parameter int unsigned MEM_ENABLE  = 1
) (
    input  logic      clk,
    input  logic      res_n,
    ctrl_mc_if.master bus,
    output logic      alusrc_pc,
    output logic      alusrc,
    output logic      immediatetoreg,
    output logic      pctoreg,
    output logic      memtoreg,
    output logic      branch,
    output logic      jump,
    output logic      memwrite,
    output logic      regwrite,
    output logic      pc_enable,
    output logic      illegal
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        C_OP,
        C_OP_IMM,
        C_LUI,
        C_AUIPC,
        C_BRANCH,
        C_JAL,
        C_JALR,
        C_LOAD,
        C_STORE
    } cls_t;

    localparam logic [TIMER_BITS-1:0] EXEC_LOAD = TIMER_BITS'(EXEC_CYCLES - 1);

    state_t                r_state, w_next;
    cls_t                  r_cls, w_cls_next, w_dec_cls;
    logic [TIMER_BITS-1:0] r_cnt, w_cnt_next;
    logic                  w_dec_legal;
    logic                  w_in_class;
    logic                  w_unused_bits;

    assign w_unused_bits = ^bus.instr_read[31:7];

    always_comb begin
        w_dec_legal = 1'b0;
        w_dec_cls   = C_OP;
        if (bus.instr_read[1:0] == 2'b11) begin
            case (bus.instr_read[6:2])
                5'b01100: begin w_dec_legal = 1'b1; w_dec_cls = C_OP;     end
                5'b00100: begin w_dec_legal = 1'b1; w_dec_cls = C_OP_IMM; end
                5'b01101: begin w_dec_legal = 1'b1; w_dec_cls = C_LUI;    end
                5'b00101: begin w_dec_legal = 1'b1; w_dec_cls = C_AUIPC;  end
                5'b11000: begin w_dec_legal = 1'b1; w_dec_cls = C_BRANCH; end
                5'b11011: begin w_dec_legal = 1'b1; w_dec_cls = C_JAL;    end
                5'b11001: begin w_dec_legal = 1'b1; w_dec_cls = C_JALR;   end
                5'b00000: begin w_dec_legal = (MEM_ENABLE != 0); w_dec_cls = C_LOAD;  end
                5'b01000: begin w_dec_legal = (MEM_ENABLE != 0); w_dec_cls = C_STORE; end
                default:  begin w_dec_legal = 1'b0; w_dec_cls = C_OP;     end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            r_state <= S_FETCH;
            r_cls   <= C_OP;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cls   <= w_cls_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cls_next = r_cls;
        w_cnt_next = r_cnt;
        case (r_state)
            S_FETCH: begin
                if (bus.instr_valid) begin
                    if (w_dec_legal) begin
                        w_cls_next = w_dec_cls;
                        w_cnt_next = EXEC_LOAD;
                        w_next     = S_EXEC;
                    end else begin
                        w_next = S_TRAP;
                    end
                end
            end
            S_EXEC: begin
                if (r_cnt == '0) begin
                    w_next = (r_cls == C_LOAD || r_cls == C_STORE) ? S_MEM : S_WB;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            S_MEM:   if (bus.mem_valid) w_next = S_WB;
            S_WB:    w_next = S_FETCH;
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
    end

    // Class selects stay stable from EXEC through WB so the datapath settles once.
    assign w_in_class = (r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB);

    always_comb begin
        bus.instr_req  = 1'b0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        alusrc_pc      = 1'b0;
        alusrc         = 1'b0;
        immediatetoreg = 1'b0;
        pctoreg        = 1'b0;
        memtoreg       = 1'b0;
        branch         = 1'b0;
        jump           = 1'b0;
        memwrite       = 1'b0;
        regwrite       = 1'b0;
        pc_enable      = 1'b0;
        illegal        = 1'b0;

        if (w_in_class) begin
            case (r_cls)
                C_OP:     alusrc = 1'b0;
                C_OP_IMM: alusrc = 1'b1;
                C_LUI:    immediatetoreg = 1'b1;
                C_AUIPC:  begin alusrc_pc = 1'b1; alusrc = 1'b1; end
                C_BRANCH: branch = 1'b1;
                C_JAL:    begin alusrc_pc = 1'b1; alusrc = 1'b1; jump = 1'b1; pctoreg = 1'b1; end
                C_JALR:   begin alusrc = 1'b1; jump = 1'b1; pctoreg = 1'b1; end
                C_LOAD:   begin alusrc = 1'b1; memtoreg = 1'b1; end
                C_STORE:  begin alusrc = 1'b1; memwrite = 1'b1; end
                default:  alusrc = 1'b0;
            endcase
        end

        case (r_state)
            S_FETCH: bus.instr_req = 1'b1;
            S_MEM: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = (r_cls == C_STORE);
            end
            S_WB: begin
                pc_enable = 1'b1;
                regwrite  = (r_cls != C_BRANCH) && (r_cls != C_STORE);
            end
            S_TRAP:  illegal = 1'b1;
            default: illegal = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_ctrl_mc.sv
// Scoreboard bench for ctrl_mc: four instances (EXEC 2/1/15, and EXEC 2 without memory ops)
// driven by directed then random instructions; a per-instance monitor checks every WB slot.
module tb_ctrl_mc;

    typedef struct {
        logic [7:0] ctl;
        logic       rw;
        int         wb;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   done [4];

    localparam logic [13:0] FETCH_VEC = 14'b100_00000000_000;
    localparam logic [13:0] TRAP_VEC  = 14'b000_00000000_001;
    localparam int          NI        = 40;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL [%0d] %s: got %0h expected %0h (cycle %0d)", k, name, act, exp, cyc);
        end
    endtask

    // Reference decode: opcode table from the ISA, ctl = {alusrc_pc, alusrc, immtoreg, pctoreg, memtoreg, branch, jump, memwrite}
    function automatic void model(input logic [31:0] ins, input int me, output bit legal,
                                  output logic [7:0] ctl, output bit rw, output bit ism, output bit st);
        legal = 1'b1; ctl = 8'h00; rw = 1'b1; ism = 1'b0; st = 1'b0;
        if (ins[1:0] != 2'b11) legal = 1'b0;
        else case (ins[6:2])
            5'b01100: ctl = 8'b0000_0000;
            5'b00100: ctl = 8'b0100_0000;
            5'b01101: ctl = 8'b0010_0000;
            5'b00101: ctl = 8'b1100_0000;
            5'b11000: begin ctl = 8'b0000_0100; rw = 1'b0; end
            5'b11011: ctl = 8'b1101_0010;
            5'b11001: ctl = 8'b0101_0010;
            5'b00000: begin ctl = 8'b0100_1000; ism = 1'b1; legal = (me != 0); end
            5'b01000: begin ctl = 8'b0100_0001; rw = 1'b0; ism = 1'b1; st = 1'b1; legal = (me != 0); end
            default:  legal = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [4:0]  ops [9];
        int          sel;
        ops = '{5'b01100, 5'b00100, 5'b01101, 5'b00101, 5'b11000, 5'b11011, 5'b11001, 5'b00000, 5'b01000};
        r   = $urandom;
        sel = int'($urandom % 12);
        if (sel < 9)        return {r[31:7], ops[sel], 2'b11};
        else if (sel == 9)  return {r[31:2], 2'b11};
        else if (sel == 10) return {r[31:7], ops[0], r[1], 1'b0};
        else                return 32'h0000000F;
    endfunction

    for (genvar k = 0; k < 4; k++) begin : g
        localparam int EC = (k == 1) ? 1 : (k == 2) ? 15 : 2;
        localparam int ME = (k == 3) ? 0 : 1;

        ctrl_mc_if bus ();
        logic res_n;
        logic alusrc_pc, alusrc, immediatetoreg, pctoreg, memtoreg;
        logic branch, jump, memwrite, regwrite, pc_enable, illegal;
        logic [13:0] ov;
        exp_t q[$];
        bit   mon_en = 1'b0;

        ctrl_mc #(.EXEC_CYCLES(EC), .TIMER_BITS(4), .MEM_ENABLE(ME)) dut (
            .clk(clk), .res_n(res_n), .bus(bus),
            .alusrc_pc(alusrc_pc), .alusrc(alusrc), .immediatetoreg(immediatetoreg),
            .pctoreg(pctoreg), .memtoreg(memtoreg), .branch(branch), .jump(jump),
            .memwrite(memwrite), .regwrite(regwrite), .pc_enable(pc_enable), .illegal(illegal)
        );

        assign ov = {bus.instr_req, bus.mem_req, bus.mem_we, alusrc_pc, alusrc, immediatetoreg,
                     pctoreg, memtoreg, branch, jump, memwrite, regwrite, pc_enable, illegal};

        always @(negedge clk) begin
            if (mon_en) begin
                bit   exp_wb;
                exp_t e;
                exp_wb = (q.size() > 0) && (q[0].wb == cyc);
                check("pc_enable", k, {31'b0, pc_enable}, {31'b0, exp_wb});
                if (exp_wb) begin
                    e = q.pop_front();
                    check("wb_vec", k, {18'b0, ov}, {18'b0, 3'b000, e.ctl, e.rw, 2'b10});
                end else begin
                    check("idle_regwrite", k, {31'b0, regwrite}, 32'd0);
                end
                while (q.size() > 0 && q[0].wb < cyc) void'(q.pop_front());
            end
        end

        initial begin
            logic [31:0] ins;
            logic [31:0] dir [11];
            logic [7:0]  ctl;
            bit          legal, rw, ism, st, abort;
            int          c, w, d;
            exp_t        e;

            dir = '{32'h00500093, 32'h0000A103, 32'h0020A023, 32'h00000063, 32'h008000EF,
                    32'h0000A103, 32'h0000000F, 32'h00500093, 32'h00008067, 32'h123450B7, 32'h00000097};
            bus.instr_valid = 1'b0; bus.mem_valid = 1'b0; bus.instr_read = '0; res_n = 1'b0;
            repeat (3) @(negedge clk);
            res_n  = 1'b1;
            mon_en = 1'b1;
            check("reset_vec", k, {18'b0, ov}, {18'b0, FETCH_VEC});

            for (int n = 0; n < NI; n++) begin
                ins = (n < 11) ? dir[n] : rand_instr();
                w = 0;
                while (bus.instr_req !== 1'b1 && w < 60) begin
                    bus.instr_valid = 1'($urandom);
                    bus.instr_read  = $urandom;
                    bus.mem_valid   = 1'($urandom);
                    @(negedge clk);
                    w++;
                end
                check("fetch_wait", k, {31'b0, bus.instr_req}, 32'd1);

                model(ins, ME, legal, ctl, rw, ism, st);
                bus.instr_valid = 1'b1;
                bus.instr_read  = ins;
                bus.mem_valid   = 1'($urandom);
                c = cyc;
                @(negedge clk);
                bus.instr_valid = 1'b0;
                bus.mem_valid   = 1'b0;

                if (!legal) begin
                    check("trap_enter", k, {18'b0, ov}, {18'b0, TRAP_VEC});
                    repeat (3) begin
                        bus.instr_valid = 1'($urandom);
                        bus.instr_read  = $urandom;
                        bus.mem_valid   = 1'($urandom);
                        @(negedge clk);
                    end
                    check("trap_hold", k, {18'b0, ov}, {18'b0, TRAP_VEC});
                    res_n = 1'b0;
                    bus.instr_valid = 1'b0;
                    @(negedge clk);
                    res_n = 1'b1;
                    check("trap_reset", k, {18'b0, ov}, {18'b0, FETCH_VEC});
                end else begin
                    check("exec_vec", k, {18'b0, ov}, {18'b0, 3'b000, ctl, 3'b000});
                    if (!ism) begin
                        e.ctl = ctl; e.rw = rw; e.wb = c + 1 + EC;
                        q.push_back(e);
                    end else begin
                        w = 0;
                        while (bus.mem_req !== 1'b1 && w < 40) begin
                            bus.mem_valid   = 1'($urandom);
                            bus.instr_valid = 1'($urandom);
                            @(negedge clk);
                            w++;
                        end
                        check("mem_req_cycle", k, cyc, c + 1 + EC);
                        d     = (n == 1) ? 3 : int'($urandom % 4);
                        abort = (n == 5) || (n >= 11 && ($urandom % 5) == 0);
                        bus.mem_valid = 1'b0;
                        repeat (d) begin
                            bus.instr_valid = 1'($urandom);
                            check("mem_hold", k, {18'b0, ov}, {18'b0, 2'b01, st, ctl, 3'b000});
                            @(negedge clk);
                        end
                        bus.instr_valid = 1'b0;
                        check("mem_last", k, {18'b0, ov}, {18'b0, 2'b01, st, ctl, 3'b000});
                        if (abort) begin
                            res_n = 1'b0;
                            @(negedge clk);
                            res_n = 1'b1;
                            check("mem_abort", k, {18'b0, ov}, {18'b0, FETCH_VEC});
                        end else begin
                            bus.mem_valid = 1'b1;
                            e.ctl = ctl; e.rw = rw; e.wb = cyc + 1;
                            q.push_back(e);
                            @(negedge clk);
                            bus.mem_valid = 1'b0;
                        end
                    end
                end
            end

            repeat (EC + 8) @(negedge clk);
            check("queue_drained", k, q.size(), 32'd0);
            done[k] = 1'b1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(done[0] && done[1] && done[2] && done[3]) && t < 30000) begin
            @(negedge clk);
            t++;
        end
        check("all_done", 4, {28'b0, done[3], done[2], done[1], done[0]}, 32'hF);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_mc.md
Name: ctrl_mc

Overview:
Parametrised multi-cycle control FSM for the RV32I core. It is the successor of the single-timer control unit.
- Sequences FETCH -> EXEC -> (MEM) -> WB per instruction.
- Adds JAL/JALR, LOAD/STORE with a data-memory handshake, configurable execute latency and a sticky illegal-instruction trap.
- Sits between the instruction-memory port and the datapath muxes, register file and PC.

Parameters:
EXEC_CYCLES, 2, cycles spent in EXEC for ALU/branch settle; legal range 1..2**TIMER_BITS-1
TIMER_BITS, 4, width of the internal EXEC down-counter
MEM_ENABLE, 1, 1 = LOAD/STORE supported; 0 = LOAD/STORE decode as illegal

Ports:
clk  in  1  clock, all state updates on rising edge
res_n  in  1  reset; synchronous, active-low
instr_read  in  32  fetched instruction; valid when instr_valid=1
instr_req  out  1  instruction fetch request
instr_valid  in  1  fetch response strobe
mem_req  out  1  data-memory request
mem_we  out  1  1 = store, 0 = load; meaningful only while mem_req=1
mem_valid  in  1  data-memory completion strobe
alusrc_pc  out  1  ALU operand A = PC
alusrc  out  1  ALU operand B: 1 = immediate, 0 = rs2
immediatetoreg  out  1  write-back source = immediate (LUI)
pctoreg  out  1  write-back source = PC+4 (JAL/JALR)
memtoreg  out  1  write-back source = load data
branch  out  1  conditional PC update on ALU compare
jump  out  1  unconditional PC = ALU result
memwrite  out  1  store in progress
regwrite  out  1  register-file write enable
pc_enable  out  1  PC register update enable
illegal  out  1  sticky trap flag

Behaviour:
- Reset (res_n=0 at a clock edge)
  - State goes to FETCH; counter = 0; illegal = 0.
  - All outputs are 0 except instr_req, which is 1 (the FETCH state value).
  - Reset asserted in any state, including mid-MEM, aborts immediately. No WB and no pc_enable occur for the aborted instruction.
- States: FETCH, EXEC, MEM, WB, TRAP. A latched opcode class register holds the decoded class (OP, OP_IMM, LUI, AUIPC, BRANCH, JAL, JALR, LOAD, STORE).
- FETCH
  - instr_req = 1; all other outputs 0.
  - On an edge with instr_valid=1, decode instr_read[6:2]: OP 01100, OP_IMM 00100, LUI 01101, AUIPC 00101, BRANCH 11000, JAL 11011, JALR 11001, LOAD 00000, STORE 01000.
  - Legal decode: latch the class, load counter = EXEC_CYCLES-1, go to EXEC.
  - Illegal decode: instr_read[1:0] != 2'b11, any unlisted opcode, or LOAD/STORE with MEM_ENABLE=0. Go to TRAP.
  - instr_valid=0: stay in FETCH.
- EXEC
  - Class datapath outputs are driven, and held constant through EXEC, MEM and WB:
    - OP: alusrc=0
    - OP_IMM: alusrc=1
    - LUI: immediatetoreg=1
    - AUIPC: alusrc_pc=1, alusrc=1
    - BRANCH: alusrc=0, branch=1
    - JAL: alusrc_pc=1, alusrc=1, jump=1, pctoreg=1
    - JALR: alusrc=1, jump=1, pctoreg=1
    - LOAD: alusrc=1, memtoreg=1
    - STORE: alusrc=1, memwrite=1
  - Counter decrements each cycle. When counter==0, go to MEM for LOAD/STORE, else to WB.
  - EXEC therefore lasts exactly EXEC_CYCLES cycles.
- MEM
  - mem_req = 1; mem_we = 1 for STORE, 0 for LOAD.
  - Hold with no timeout until an edge with mem_valid=1, then go to WB.
  - mem_valid outside MEM is ignored.
- WB
  - Exactly one cycle: pc_enable=1.
  - regwrite=1 for all classes except BRANCH and STORE.
  - Next state is FETCH.
- instr_valid outside FETCH is ignored.
- TRAP
  - illegal = 1; instr_req, mem_req, pc_enable and regwrite are 0.
  - Stays in TRAP until reset.
- Latency: with instr_valid sampled at edge t, WB occupies cycle t+EXEC_CYCLES+1 for non-memory classes. For LOAD/STORE, WB is the cycle after the mem_valid edge.
- pc_enable and regwrite are asserted only in WB, never more than once per instruction.

Test Plan:
- EXEC_CYCLES=2: OP_IMM 0x00500093 (addi x1,x0,5) with instr_valid pulse -> 2 EXEC cycles with alusrc=1, then a 1-cycle WB with regwrite=1 and pc_enable=1, instr_req=1 the next cycle; total 4 cycles FETCH-to-FETCH.
- LOAD 0x0000A103 with mem_valid delayed 3 cycles -> mem_req=1, mem_we=0 held for 3 cycles; memtoreg=1 throughout; WB regwrite=1 one cycle after mem_valid.
- STORE 0x0020A023 -> mem_we=1, memwrite=1; WB has pc_enable=1, regwrite=0. BEQ 0x00000063 -> branch=1, WB regwrite=0.
- JAL 0x008000EF -> jump=1, pctoreg=1, alusrc_pc=1; WB regwrite=1. Repeat with EXEC_CYCLES=1 and EXEC_CYCLES=15 to confirm EXEC lengths of 1 and 15.
- Opcode 0x0000000F (MISC-MEM), and LOAD with MEM_ENABLE=0 -> TRAP: illegal=1, instr_req=0, stays there; res_n=0 for one edge -> FETCH, illegal=0.
- res_n=0 asserted during MEM -> next cycle FETCH, mem_req=0, no pc_enable/regwrite pulse; following instruction completes normally.
